// File: rtl/fast_adder_4_pkg.sv
// fast_adder_4_pkg: shared width and output-register reset values for fast_adder_4
package fast_adder_4_pkg;
  localparam int ADD_W = 4;
  localparam logic [ADD_W-1:0] SUM_RST = '0;
  localparam logic BIT_RST = 1'b0;
endpackage

// File: rtl/cla_unit_4.sv
// cla_unit_4: flat 4-bit carry-lookahead unit, reusable as a second-level lookahead
module cla_unit_4
  import fast_adder_4_pkg::*;
(
  input  logic [ADD_W-1:0] p,
  input  logic [ADD_W-1:0] g,
  input  logic             c_in,
  output logic [ADD_W:1]   c,
  output logic             grp_p,
  output logic             grp_g
);
  assign c[1]  = g[0] | p[0] & c_in;
  assign c[2]  = g[1] | p[1] & g[0] | p[1] & p[0] & c_in;
  assign c[3]  = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c_in;
  assign grp_g = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
  assign grp_p = &p;
  assign c[4]  = grp_g | grp_p & c_in;
endmodule

// File: rtl/fast_adder_4.sv
// fast_adder_4: registered 4-bit CLA adder; FAST_ADDER_4_OVF_EN adds a signed-overflow output
module fast_adder_4
  import fast_adder_4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             c_in,
  output logic [ADD_W-1:0] sum,
  output logic             c_out,
  output logic             grp_p,
  output logic             grp_g,
  output logic             out_valid
`ifdef FAST_ADDER_4_OVF_EN
  ,
  output logic             ovf
`endif
);
  logic [ADD_W-1:0] p, g, sum_d, sum_q;
  logic [ADD_W:1] c;
  logic gp_d, gg_d, c_out_q, grp_p_q, grp_g_q, out_valid_q;
  assign p = a ^ b;
  assign g = a & b;
  cla_unit_4 u_cla (
    .p    (p),
    .g    (g),
    .c_in (c_in),
    .c    (c),
    .grp_p(gp_d),
    .grp_g(gg_d)
  );
  assign sum_d = p ^ {c[3:1], c_in};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= SUM_RST;
      c_out_q     <= BIT_RST;
      grp_p_q     <= BIT_RST;
      grp_g_q     <= BIT_RST;
      out_valid_q <= BIT_RST;
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c[4];
      grp_p_q     <= gp_d;
      grp_g_q     <= gg_d;
      out_valid_q <= in_valid;
    end
  end
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign grp_p     = grp_p_q;
  assign grp_g     = grp_g_q;
  assign out_valid = out_valid_q;
`ifdef FAST_ADDER_4_OVF_EN
  logic ovf_q;
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= BIT_RST;
    else ovf_q <= c[3] ^ c[4];
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_fast_adder_4.sv
// tb_fast_adder_4: directed table, reset/valid sequences and full 512-case sweep
module tb_fast_adder_4;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, c_in = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [3:0] sum;
  logic c_out, grp_p, grp_g, out_valid;
`ifdef FAST_ADDER_4_OVF_EN
  logic ovf;
`endif
  int n_cmp = 0, n_bad = 0;

  fast_adder_4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sum      (sum),
    .c_out    (c_out),
    .grp_p    (grp_p),
    .grp_g    (grp_g),
    .out_valid(out_valid)
`ifdef FAST_ADDER_4_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b;
    logic ci, v;
    logic [3:0] s;
    logic co, p, g;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] xa, input logic [3:0] xb, input logic xc, input logic xv);
    a = xa;
    b = xb;
    c_in = xc;
    in_valid = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_sum"}, sum, 0);
    chk({nm, "_cout"}, c_out, 0);
    chk({nm, "_p"}, grp_p, 0);
    chk({nm, "_g"}, grp_g, 0);
    chk({nm, "_vld"}, out_valid, 0);
`ifdef FAST_ADDER_4_OVF_EN
    chk({nm, "_ovf"}, ovf, 0);
`endif
  endtask

  initial begin
    vec_t tv[8];
    tv[0] = '{4'd15, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
    tv[1] = '{4'd15, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1};
    tv[2] = '{4'd5,  4'd10, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0};
    tv[3] = '{4'd5,  4'd10, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
    tv[4] = '{4'd0,  4'd0,  1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
    tv[5] = '{4'd3,  4'd4,  1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0};
    tv[6] = '{4'd9,  4'd9,  1'b0, 1'b0, 4'd2,  1'b1, 1'b0, 1'b1};
    tv[7] = '{4'd6,  4'd3,  1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0};

    #1 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    drive(4'd9, 4'd9, 1'b0, 1'b1);
    chk_zero("rst_held");
    rst_n = 1'b1;
    drive(4'd9, 4'd9, 1'b0, 1'b1);
    chk("post_rst_sum", sum, 2);
    chk("post_rst_cout", c_out, 1);
    chk("post_rst_vld", out_valid, 1);
    rst_n = 1'b0;
    #2 chk_zero("rst_mid_op");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_sum", sum, 2);
    chk("rel_cout", c_out, 1);

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].ci, tv[i].v);
      chk($sformatf("tv%0d_sum", i), sum, tv[i].s);
      chk($sformatf("tv%0d_cout", i), c_out, tv[i].co);
      chk($sformatf("tv%0d_p", i), grp_p, tv[i].p);
      chk($sformatf("tv%0d_g", i), grp_g, tv[i].g);
      chk($sformatf("tv%0d_vld", i), out_valid, tv[i].v);
    end

    drive(4'd0, 4'd0, 1'b0, 1'b0);
    drive(4'd3, 4'd4, 1'b0, 1'b1);
    chk("pulse_vld1", out_valid, 1);
    chk("pulse_sum", sum, 7);
    drive(4'd3, 4'd4, 1'b0, 1'b0);
    chk("pulse_vld0", out_valid, 0);
    drive(4'd3, 4'd4, 1'b0, 1'b0);
    chk("pulse_vld0b", out_valid, 0);

`ifdef FAST_ADDER_4_OVF_EN
    drive(4'd7, 4'd1, 1'b0, 1'b1);
    chk("ovf_7p1", ovf, 1);
    drive(4'd8, 4'd8, 1'b0, 1'b1);
    chk("ovf_8p8", ovf, 1);
    chk("ovf_8p8_cout", c_out, 1);
    chk("ovf_8p8_sum", sum, 0);
    drive(4'd12, 4'd2, 1'b0, 1'b1);
    chk("ovf_12p2", ovf, 0);
    drive(4'd3, 4'd2, 1'b0, 1'b1);
    chk("ovf_3p2", ovf, 0);
`endif

    for (int k = 0; k < 512; k++) begin
      logic [8:0] kk;
      int tot;
      kk = 9'(k);
      drive(kk[4:1], kk[8:5], kk[0], 1'b1);
      tot = int'(a) + int'(b) + int'(c_in);
      chk($sformatf("sweep_%0d+%0d+%0d", a, b, c_in), {c_out, sum}, tot);
      chk($sformatf("sweep_p_%0d_%0d", a, b), grp_p, (a ^ b) == 4'hF);
      chk($sformatf("sweep_g_%0d_%0d", a, b), grp_g, (int'(a) + int'(b)) > 15);
`ifdef FAST_ADDER_4_OVF_EN
      chk($sformatf("sweep_ovf_%0d_%0d_%0d", a, b, c_in), ovf,
          (a[3] == b[3]) && (tot[3] != a[3]));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
